// File: rtl/free_list.sv
// rtl/free_list.sv - circular free list of physical register IDs feeding rename
//
// Keeps a circular buffer of free physical register IDs. Each cycle it hands
// out up to NUM_DECODE IDs, packed slot-by-slot for rename, and takes back up
// to NUM_COMMIT stale IDs from commit.
//
// Optional build macro: FREE_LIST_CHECK_EN adds the sticky err output and
// drops frees that would overflow the list or carry an out-of-range ID.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   alloc_req        per decode slot: slot needs a destination register
//   alloc_ready      at least NUM_DECODE entries are free (registered count)
//   phyreg_flatten   allocated IDs, slot 0 in the MSBs, unrequested slots 0
//   free_valid       per commit slot: slot returns a register
//   free_phy_flatten returned IDs, slot 0 in the MSBs
//   free_count       registered number of free entries
//   err              (FREE_LIST_CHECK_EN only) sticky protocol-violation flag

module free_list #(
    parameter int NUM_DECODE = 4,
    parameter int NUM_COMMIT = 4,
    parameter int NUM_PHY    = 380,
    parameter int PHY_WIDTH  = $clog2(NUM_PHY),
    parameter int NUM_ARCH   = 31,
    parameter int CNT_WIDTH  = $clog2(NUM_PHY + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_DECODE-1:0]           alloc_req,
    output logic                            alloc_ready,
    output logic [PHY_WIDTH*NUM_DECODE-1:0] phyreg_flatten,
    input  logic [NUM_COMMIT-1:0]           free_valid,
    input  logic [PHY_WIDTH*NUM_COMMIT-1:0] free_phy_flatten,
    output logic [CNT_WIDTH-1:0]            free_count
`ifdef FREE_LIST_CHECK_EN
    ,
    output logic                            err
`endif
);

    localparam int NUM_FREE_RST = NUM_PHY - NUM_ARCH;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_DECODE   = CNT_WIDTH'(NUM_DECODE);
    localparam logic [CNT_WIDTH-1:0] CNT_FREE_RST = CNT_WIDTH'(NUM_FREE_RST);

    // Pointer advance with wrap by explicit compare (depth is not a power of 2).
    // Callers guarantee base < NUM_PHY and off <= NUM_PHY, so one subtract suffices.
    function automatic logic [CNT_WIDTH-1:0] wrap_add(
        input logic [CNT_WIDTH-1:0] base,
        input logic [CNT_WIDTH-1:0] off
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (CNT_WIDTH+1)'(NUM_PHY)) begin
            sum = sum - (CNT_WIDTH+1)'(NUM_PHY);
        end
        return sum[CNT_WIDTH-1:0];
    endfunction

    logic [CNT_WIDTH-1:0] head_q, head_d;
    logic [CNT_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic [PHY_WIDTH-1:0] mem_rd [NUM_PHY];

    // ------------------------------------------------------------------
    // Allocation: combinational packing from head
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] nalloc;
    logic [CNT_WIDTH-1:0] rd_idx;

    assign alloc_ready = (count_q >= CNT_DECODE);

    always_comb begin
        nalloc         = '0;
        rd_idx         = '0;
        phyreg_flatten = '0;
        for (int i = 0; i < NUM_DECODE; i++) begin
            // nalloc here counts requesting slots below i: that is this slot's offset
            rd_idx = wrap_add(head_q, nalloc);
            if (alloc_ready && alloc_req[i]) begin
                phyreg_flatten[PHY_WIDTH*(NUM_DECODE-1-i) +: PHY_WIDTH] = mem_rd[rd_idx];
            end
            if (alloc_req[i]) begin
                nalloc = nalloc + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Free: compact valid slots onto consecutive entries from tail
    // ------------------------------------------------------------------
    logic [PHY_WIDTH-1:0]  free_id [NUM_COMMIT];
    logic [CNT_WIDTH-1:0]  wr_idx  [NUM_COMMIT];
    logic [NUM_COMMIT-1:0] accept;
    logic [CNT_WIDTH-1:0]  nfree;

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_COMMIT-1:0] legal;
    logic [CNT_WIDTH-1:0]  nlegal;
    logic                  bad_id;
    logic                  overflow;
    logic                  err_q, err_d;

    // A slot is legal when valid and in range. If the legal frees together
    // would overfill the list, the whole batch is dropped.
    always_comb begin
        legal  = '0;
        nlegal = '0;
        bad_id = 1'b0;
        for (int j = 0; j < NUM_COMMIT; j++) begin
            if (free_valid[j]) begin
                if ({1'b0, free_phy_flatten[PHY_WIDTH*(NUM_COMMIT-1-j) +: PHY_WIDTH]}
                        < (PHY_WIDTH+1)'(NUM_PHY)) begin
                    legal[j] = 1'b1;
                    nlegal   = nlegal + CNT_ONE;
                end else begin
                    bad_id = 1'b1;
                end
            end
        end
        overflow = ({1'b0, count_q} + {1'b0, nlegal}) > (CNT_WIDTH+1)'(NUM_PHY);
        accept   = overflow ? '0 : legal;
        err_d    = err_q | overflow | bad_id;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign accept = free_valid;
`endif

    always_comb begin
        nfree = '0;
        for (int j = 0; j < NUM_COMMIT; j++) begin
            free_id[j] = free_phy_flatten[PHY_WIDTH*(NUM_COMMIT-1-j) +: PHY_WIDTH];
            wr_idx[j]  = wrap_add(tail_q, nfree);
            if (accept[j]) begin
                nfree = nfree + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer and count next state
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = alloc_ready ? wrap_add(head_q, nalloc) : head_q;
        tail_d  = wrap_add(tail_q, nfree);
        count_d = count_q - (alloc_ready ? nalloc : '0) + nfree;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= CNT_FREE_RST;
            count_q <= CNT_FREE_RST;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign free_count = count_q;

    // ------------------------------------------------------------------
    // Storage: one register per entry. Reset loads the IDs left unmapped
    // by the rename table's identity reset mapping.
    // ------------------------------------------------------------------
    for (genvar e = 0; e < NUM_PHY; e++) begin : g_ent
        localparam logic [PHY_WIDTH-1:0] RST_VAL =
            (e < NUM_FREE_RST) ? PHY_WIDTH'(NUM_ARCH + e) : '0;

        logic                 wen;
        logic [PHY_WIDTH-1:0] wdata;
        logic [PHY_WIDTH-1:0] ent_q;

        // Accepted slots target distinct entries, so at most one matches.
        always_comb begin
            wen   = 1'b0;
            wdata = '0;
            for (int j = 0; j < NUM_COMMIT; j++) begin
                if (accept[j] && (wr_idx[j] == CNT_WIDTH'(e))) begin
                    wen   = 1'b1;
                    wdata = free_id[j];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ent_q <= RST_VAL;
            end else if (wen) begin
                ent_q <= wdata;
            end
        end

        assign mem_rd[e] = ent_q;
    end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - self-checking bench for free_list

module tb_free_list;

    localparam int ND = 4;
    localparam int NC = 4;
    localparam int NP = 380;
    localparam int PW = 9;
    localparam int NA = 31;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] alloc_req;
    logic          alloc_ready;
    logic [PW*ND-1:0] phyreg_flatten;
    logic [NC-1:0] free_valid;
    logic [PW*NC-1:0] free_phy_flatten;
    logic [CW-1:0] free_count;
`ifdef FREE_LIST_CHECK_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    free_list dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_req        (alloc_req),
        .alloc_ready      (alloc_ready),
        .phyreg_flatten   (phyreg_flatten),
        .free_valid       (free_valid),
        .free_phy_flatten (free_phy_flatten),
        .free_count       (free_count)
`ifdef FREE_LIST_CHECK_EN
        ,
        .err              (err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ordered queue of free IDs, front is the next allocated.
    int mq[$];
    int tail_m;
    bit err_m;

    typedef struct {
        logic [PW*ND-1:0] flat;
        logic             ready;
        int               count;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [ND-1:0]    req;
        logic [NC-1:0]    fv;
        int               id0, id1, id2, id3;
        logic [PW*ND-1:0] e_flat;
        logic             e_ready;
        int               e_count;
    } vec_t;

    function automatic logic [PW*ND-1:0] pack4(input int a, input int b, input int c, input int d);
        return {PW'(a), PW'(b), PW'(c), PW'(d)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int k = NA; k < NP; k++) mq.push_back(k);
        tail_m = NP - NA;
        err_m  = 1'b0;
    endtask

    // One cycle: drive at posedge+1, compare at negedge, update model at posedge.
    task automatic step(input logic [ND-1:0] req, input logic [NC-1:0] fv,
                        input int id0, input int id1, input int id2, input int id3,
                        input string tag, input bit have_exp,
                        input logic [PW*ND-1:0] e_flat, input logic e_ready, input int e_count);
        int ids[NC];
        exp_t e;
        exp_t got;
        int k;
        int nlegal;
        int pushed;
        bit bad;
        logic [PW*ND-1:0] mflat;
        bit mready;
        ids[0] = id0; ids[1] = id1; ids[2] = id2; ids[3] = id3;
        alloc_req  = req;
        free_valid = fv;
        for (int j = 0; j < NC; j++) free_phy_flatten[PW*(NC-1-j) +: PW] = PW'(ids[j]);

        mready = (mq.size() >= ND);
        mflat  = '0;
        k      = 0;
        for (int i = 0; i < ND; i++) begin
            if (mready && req[i]) begin
                mflat[PW*(ND-1-i) +: PW] = PW'(mq[k]);
                k++;
            end
        end
        if (have_exp) begin
            e.flat = e_flat; e.ready = e_ready; e.count = e_count;
        end else begin
            e.flat = mflat; e.ready = mready; e.count = mq.size();
        end
        sb.push_back(e);

        @(negedge clk);
        got = sb.pop_front();
        check({tag, ".flat"},  phyreg_flatten, got.flat);
        check({tag, ".ready"}, alloc_ready,    got.ready);
        check({tag, ".count"}, free_count,     got.count);
`ifdef FREE_LIST_CHECK_EN
        check({tag, ".err"},   err,            err_m);
`endif

        @(posedge clk);
        nlegal = 0;
        bad    = 1'b0;
        for (int j = 0; j < NC; j++) begin
            if (fv[j]) begin
                if (ids[j] < NP) nlegal++;
                else bad = 1'b1;
            end
        end
        pushed = 0;
`ifdef FREE_LIST_CHECK_EN
        if (bad || (mq.size() + nlegal > NP)) err_m = 1'b1;
        if (mq.size() + nlegal <= NP) begin
            for (int j = 0; j < NC; j++) begin
                if (fv[j] && ids[j] < NP) begin
                    mq.push_back(ids[j]);
                    pushed++;
                end
            end
        end
`else
        for (int j = 0; j < NC; j++) begin
            if (fv[j]) begin
                mq.push_back(ids[j]);
                pushed++;
            end
        end
`endif
        for (int i = 0; i < k; i++) void'(mq.pop_front());
        tail_m = (tail_m + pushed) % NP;
        #1;
    endtask

    task automatic idle(input string tag);
        step('0, '0, 0, 0, 0, 0, tag, 1'b0, '0, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        alloc_req  = '0;
        free_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[6];

    initial begin
        logic [ND-1:0] r;
        logic [NC-1:0] m;
        int n;
        int rem;

        vt[0] = '{4'b0000, 4'b0000, 0, 0, 0, 0, pack4(0, 0, 0, 0),     1'b1, 349};
        vt[1] = '{4'b1111, 4'b0000, 0, 0, 0, 0, pack4(31, 32, 33, 34), 1'b1, 349};
        vt[2] = '{4'b1010, 4'b0000, 0, 0, 0, 0, pack4(0, 35, 0, 36),   1'b1, 345};
        vt[3] = '{4'b0001, 4'b0000, 0, 0, 0, 0, pack4(37, 0, 0, 0),    1'b1, 343};
        vt[4] = '{4'b0000, 4'b0011, 2, 9, 0, 0, pack4(0, 0, 0, 0),     1'b1, 342};
        vt[5] = '{4'b0000, 4'b0000, 0, 0, 0, 0, pack4(0, 0, 0, 0),     1'b1, 344};

        alloc_req        = '0;
        free_valid       = '0;
        free_phy_flatten = '0;
        rst              = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        for (int v = 0; v < 6; v++) begin
            step(vt[v].req, vt[v].fv, vt[v].id0, vt[v].id1, vt[v].id2, vt[v].id3,
                 $sformatf("vec%0d", v), 1'b1, vt[v].e_flat, vt[v].e_ready, vt[v].e_count);
        end

        // Drain down to 3 free entries.
        while (mq.size() > 4) step(4'b1111, '0, 0, 0, 0, 0, "drain", 1'b0, '0, 1'b0, 0);
        step(4'b0001, '0, 0, 0, 0, 0, "drain_last", 1'b0, '0, 1'b0, 0);
        step(4'b1111, '0, 0, 0, 0, 0, "stall", 1'b1, '0, 1'b0, 3);
        step(4'b1111, 4'b0001, 120, 0, 0, 0, "stall_free", 1'b1, '0, 1'b0, 3);
        step(4'b0000, '0, 0, 0, 0, 0, "refill", 1'b1, '0, 1'b1, 4);

        // Advance tail to 378, then free across the wrap.
        while (tail_m != 378) begin
            n = 378 - tail_m;
            if (n > 4) n = 4;
            m = 4'b1111 >> (4 - n);
            step('0, m, 200, 201, 202, 203, "tail_adv", 1'b0, '0, 1'b0, 0);
        end
        step('0, 4'b1111, 5, 6, 7, 8, "wrap_free", 1'b0, '0, 1'b0, 0);
        check("tail_model_wrap", tail_m, 2);

        // Allocate until only the wrapped IDs remain.
        while (mq.size() > 4) begin
            rem = mq.size() - 4;
            r   = (rem >= 4) ? 4'b1111 : (4'b1111 >> (4 - rem));
            step(r, '0, 0, 0, 0, 0, "wrap_drain", 1'b0, '0, 1'b0, 0);
        end
        step(4'b1111, 4'b0011, 50, 51, 0, 0, "wrap_alloc", 1'b1, pack4(5, 6, 7, 8), 1'b1, 4);
        step(4'b1111, '0, 0, 0, 0, 0, "no_bypass", 1'b1, '0, 1'b0, 2);

        // Random mixed traffic against the model.
        for (int c = 0; c < 200; c++) begin
            r = 4'($urandom);
            m = (mq.size() + 4 <= NP) ? 4'($urandom) : 4'b0000;
            step(r, m, $urandom_range(NP - 1), $urandom_range(NP - 1),
                 $urandom_range(NP - 1), $urandom_range(NP - 1), "rand", 1'b0, '0, 1'b0, 0);
        end

        // Asynchronous reset mid-cycle, with frees pending.
        alloc_req  = 4'b1111;
        free_valid = 4'b1111;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst.count", free_count, 349);
        check("async_rst.ready", alloc_ready, 1'b1);
        check("async_rst.flat",  phyreg_flatten, pack4(31, 32, 33, 34));
        @(negedge clk);
        free_valid = '0;
        alloc_req  = '0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step(4'b1111, '0, 0, 0, 0, 0, "post_rst", 1'b1, pack4(31, 32, 33, 34), 1'b1, 349);

`ifdef FREE_LIST_CHECK_EN
        do_reset();
        while (mq.size() < 378) begin
            n = 378 - mq.size();
            if (n > 4) n = 4;
            m = 4'b1111 >> (4 - n);
            step('0, m, 100, 101, 102, 103, "fill", 1'b0, '0, 1'b0, 0);
        end
        step('0, 4'b1111, 1, 2, 3, 4, "ovf_free", 1'b1, '0, 1'b1, 378);
        step('0, '0, 0, 0, 0, 0, "ovf_after", 1'b1, '0, 1'b1, 378);
        check("ovf_err", err, 1'b1);

        do_reset();
        step('0, 4'b0001, 400, 0, 0, 0, "badid_free", 1'b1, '0, 1'b1, 349);
        step('0, '0, 0, 0, 0, 0, "badid_after", 1'b1, '0, 1'b1, 349);
        check("badid_err", err, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
